rename_register_file: RTL and testbench

Parametrised architectural register file with per-register rename tags. It sits between the instruction unit and the reorder buffer (ROB). It generalises the two-read/one-commit register file to READ_PORTS read ports and COMMIT_PORTS commit ports, with fully clocked state updates and defined same-cycle precedence. Each read port returns the committed value, or the ROB-forwarded value, or the dependency tag.

---
 rtl/rf_pkg.sv | 25 ++
 rtl/rename_register_file_if.sv | 51 +++++
 rtl/rf_read_port.sv | 81 ++++++++
 rtl/rename_register_file.sv | 100 ++++++++++
 tb/tb_rename_register_file.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared types, default widths and helpers for the rename register file.
package rf_pkg;

  localparam int DEF_ROB_WIDTH    = 4;
  localparam int DEF_XLEN         = 32;
  localparam int DEF_REG_COUNT    = 32;
  localparam int DEF_READ_PORTS   = 2;
  localparam int DEF_COMMIT_PORTS = 1;

  // Architectural register hardwired to zero.
  localparam int REG_ZERO = 0;

  // Register address width for a power-of-two register count.
  function automatic int rf_aw(input int regCount);
    return $clog2(regCount);
  endfunction

  // One architectural register at the default widths.
  typedef struct packed {
    logic [DEF_XLEN-1:0]      value;
    logic                     busy;
    logic [DEF_ROB_WIDTH-1:0] tag;
  } rf_entry_t;

endpackage

// File: rtl/rename_register_file_if.sv
// Bus between the instruction unit / ROB (master) and the rename register file (slave).
interface rename_register_file_if #(
  parameter int ROB_WIDTH    = rf_pkg::DEF_ROB_WIDTH,
  parameter int XLEN         = rf_pkg::DEF_XLEN,
  parameter int REG_COUNT    = rf_pkg::DEF_REG_COUNT,
  parameter int READ_PORTS   = rf_pkg::DEF_READ_PORTS,
  parameter int COMMIT_PORTS = rf_pkg::DEF_COMMIT_PORTS
);
  localparam int AW = rf_pkg::rf_aw(REG_COUNT);

  // Handshake semantics: rfUpdateValid and regUpdateValid qualify their
  // payload for exactly the cycle they are high; the register file always
  // accepts, so there is no back-pressure. robRdReady is not a handshake: it
  // is the ROB's combinational answer to robRdDep in the same cycle.

  // read side
  logic [READ_PORTS*AW-1:0]          rdAddr;
  logic [READ_PORTS-1:0]             rdDirty;
  logic [READ_PORTS*ROB_WIDTH-1:0]   rdDependency;
  logic [READ_PORTS*XLEN-1:0]        rdValue;

  // rename
  logic                              rfUpdateValid;
  logic [AW-1:0]                     rfUpdateDest;
  logic [ROB_WIDTH-1:0]              rfUpdateRobId;

  // ROB lookup
  logic [READ_PORTS*ROB_WIDTH-1:0]   robRdDep;
  logic [READ_PORTS-1:0]             robRdReady;
  logic [READ_PORTS*XLEN-1:0]        robRdValue;

  // commit
  logic [COMMIT_PORTS-1:0]           regUpdateValid;
  logic [COMMIT_PORTS*AW-1:0]        regUpdateDest;
  logic [COMMIT_PORTS*XLEN-1:0]      regUpdateValue;
  logic [COMMIT_PORTS*ROB_WIDTH-1:0] regUpdateRobId;

  modport slave (
    input  rdAddr, rfUpdateValid, rfUpdateDest, rfUpdateRobId,
    input  robRdReady, robRdValue,
    input  regUpdateValid, regUpdateDest, regUpdateValue, regUpdateRobId,
    output rdDirty, rdDependency, rdValue, robRdDep
  );

  modport master (
    output rdAddr, rfUpdateValid, rfUpdateDest, rfUpdateRobId,
    output robRdReady, robRdValue,
    output regUpdateValid, regUpdateDest, regUpdateValue, regUpdateRobId,
    input  rdDirty, rdDependency, rdValue, robRdDep
  );
endinterface

// File: rtl/rf_read_port.sv
// One read port: address latch, operand select and optional commit bypass.
// Optional feature macro: RF_COMMIT_BYPASS_EN forwards a same-cycle commit
// whose tag matches the register's current tag.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int ROB_WIDTH    = DEF_ROB_WIDTH,
  parameter int XLEN         = DEF_XLEN,
  parameter int AW           = 5,
  parameter int COMMIT_PORTS = DEF_COMMIT_PORTS
) (
  input  logic                              clockIn,
  input  logic                              resetIn,
  input  logic [AW-1:0]                     addrIn,
  output logic [AW-1:0]                     addrQ,
  input  logic [XLEN-1:0]                   entValue,
  input  logic                              entBusy,
  input  logic [ROB_WIDTH-1:0]              entTag,
  input  logic                              robReady,
  input  logic [XLEN-1:0]                   robValue,
  input  logic [COMMIT_PORTS-1:0]           commitValid,
  input  logic [COMMIT_PORTS*AW-1:0]        commitDest,
  input  logic [COMMIT_PORTS*XLEN-1:0]      commitValue,
  input  logic [COMMIT_PORTS*ROB_WIDTH-1:0] commitTag,
  output logic                              dirty,
  output logic [ROB_WIDTH-1:0]              dependency,
  output logic [XLEN-1:0]                   value,
  output logic [ROB_WIDTH-1:0]              robDep
);

  logic            isZero;
  logic            bypassHit;
  logic [XLEN-1:0] bypassValue;

  // Latch the read address every cycle, including during a flush.
  always_ff @(posedge clockIn) begin
    if (!resetIn) addrQ <= '0;
    else          addrQ <= addrIn;
  end

  assign isZero = (addrQ == AW'(REG_ZERO));

`ifdef RF_COMMIT_BYPASS_EN
  // Find the highest-index commit to this register carrying its current tag.
  always_comb begin
    bypassHit   = 1'b0;
    bypassValue = '0;
    for (int c = 0; c < COMMIT_PORTS; c++) begin
      if (commitValid[c] && (commitDest[c*AW +: AW] == addrQ) &&
          (commitTag[c*ROB_WIDTH +: ROB_WIDTH] == entTag)) begin
        bypassHit   = 1'b1;
        bypassValue = commitValue[c*XLEN +: XLEN];
      end
    end
  end
`else
  assign bypassHit   = 1'b0;
  assign bypassValue = '0;
  logic unusedCommit;
  assign unusedCommit = ^{commitValid, commitDest, commitValue, commitTag};
`endif

  // Select the operand: zero register, bypassed commit, ROB value or committed value.
  always_comb begin
    robDep     = entTag;
    dependency = entTag;
    dirty      = 1'b0;
    value      = '0;
    if (isZero) begin
      dirty = 1'b0;
      value = '0;
    end else if (bypassHit) begin
      dirty = 1'b0;
      value = bypassValue;
    end else begin
      dirty = entBusy & ~robReady;
      value = entBusy ? robValue : entValue;
    end
  end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename tags, multiple read
// and commit ports. Owns register state and the commit/rename update.
// Optional feature macro: RF_COMMIT_BYPASS_EN (handled in rf_read_port).
module rename_register_file
  import rf_pkg::*;
#(
  parameter int ROB_WIDTH    = DEF_ROB_WIDTH,
  parameter int XLEN         = DEF_XLEN,
  parameter int REG_COUNT    = DEF_REG_COUNT,
  parameter int READ_PORTS   = DEF_READ_PORTS,
  parameter int COMMIT_PORTS = DEF_COMMIT_PORTS
) (
  input logic                  clockIn,
  input logic                  resetIn,
  input logic                  clearIn,
  rename_register_file_if.slave bus
);
  localparam int AW = rf_aw(REG_COUNT);

  logic [XLEN-1:0]      valueQ [REG_COUNT];
  logic [XLEN-1:0]      valueD [REG_COUNT];
  logic [REG_COUNT-1:0] busyQ;
  logic [REG_COUNT-1:0] busyD;
  logic [ROB_WIDTH-1:0] tagQ   [REG_COUNT];
  logic [ROB_WIDTH-1:0] tagD   [REG_COUNT];

  logic [AW-1:0]        cDest  [COMMIT_PORTS];
  logic [XLEN-1:0]      cValue [COMMIT_PORTS];
  logic [ROB_WIDTH-1:0] cTag   [COMMIT_PORTS];

  for (genvar c = 0; c < COMMIT_PORTS; c++) begin : g_commit
    assign cDest[c]  = bus.regUpdateDest[c*AW +: AW];
    assign cValue[c] = bus.regUpdateValue[c*XLEN +: XLEN];
    assign cTag[c]   = bus.regUpdateRobId[c*ROB_WIDTH +: ROB_WIDTH];
  end

  // Next state: commits in index order (higher wins), then flush, then rename.
  always_comb begin
    valueD = valueQ;
    busyD  = busyQ;
    tagD   = tagQ;
    for (int c = 0; c < COMMIT_PORTS; c++) begin
      if (bus.regUpdateValid[c] && (cDest[c] != AW'(REG_ZERO))) begin
        valueD[cDest[c]] = cValue[c];
        if (cTag[c] == tagQ[cDest[c]]) busyD[cDest[c]] = 1'b0;
      end
    end
    if (clearIn) begin
      busyD = '0;
    end else if (bus.rfUpdateValid && (bus.rfUpdateDest != AW'(REG_ZERO))) begin
      busyD[bus.rfUpdateDest] = 1'b1;
      tagD[bus.rfUpdateDest]  = bus.rfUpdateRobId;
    end
  end

  // Register state; reset wipes everything, including pending updates.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        valueQ[r] <= '0;
        tagQ[r]   <= '0;
      end
      busyQ <= '0;
    end else begin
      valueQ <= valueD;
      busyQ  <= busyD;
      tagQ   <= tagD;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
    logic [AW-1:0] addrQ;

    rf_read_port #(
      .ROB_WIDTH   (ROB_WIDTH),
      .XLEN        (XLEN),
      .AW          (AW),
      .COMMIT_PORTS(COMMIT_PORTS)
    ) u_port (
      .clockIn    (clockIn),
      .resetIn    (resetIn),
      .addrIn     (bus.rdAddr[p*AW +: AW]),
      .addrQ      (addrQ),
      .entValue   (valueQ[addrQ]),
      .entBusy    (busyQ[addrQ]),
      .entTag     (tagQ[addrQ]),
      .robReady   (bus.robRdReady[p]),
      .robValue   (bus.robRdValue[p*XLEN +: XLEN]),
      .commitValid(bus.regUpdateValid),
      .commitDest (bus.regUpdateDest),
      .commitValue(bus.regUpdateValue),
      .commitTag  (bus.regUpdateRobId),
      .dirty      (bus.rdDirty[p]),
      .dependency (bus.rdDependency[p*ROB_WIDTH +: ROB_WIDTH]),
      .value      (bus.rdValue[p*XLEN +: XLEN]),
      .robDep     (bus.robRdDep[p*ROB_WIDTH +: ROB_WIDTH])
    );
  end

endmodule

// File: tb/tb_rename_register_file.sv
// Directed bench for rename_register_file with two read and two commit ports.
module tb_rename_register_file;
  localparam int RW = 4;
  localparam int XL = 32;
  localparam int RC = 32;
  localparam int RP = 2;
  localparam int CP = 2;
  localparam int AW = 5;

  logic clk;
  logic rst_n;
  logic clear;
  int   total;
  int   bad;

  rename_register_file_if #(
    .ROB_WIDTH(RW), .XLEN(XL), .REG_COUNT(RC), .READ_PORTS(RP), .COMMIT_PORTS(CP)
  ) bus ();

  rename_register_file #(
    .ROB_WIDTH(RW), .XLEN(XL), .REG_COUNT(RC), .READ_PORTS(RP), .COMMIT_PORTS(CP)
  ) dut (
    .clockIn(clk),
    .resetIn(rst_n),
    .clearIn(clear),
    .bus    (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rfUpdateValid  = 1'b0;
    bus.rfUpdateDest   = '0;
    bus.rfUpdateRobId  = '0;
    bus.regUpdateValid = '0;
    bus.regUpdateDest  = '0;
    bus.regUpdateValue = '0;
    bus.regUpdateRobId = '0;
    bus.robRdReady     = '0;
    bus.robRdValue     = '0;
    clear              = 1'b0;
  endtask

  task automatic set_addr(input int p, input logic [AW-1:0] a);
    bus.rdAddr[p*AW +: AW] = a;
  endtask

  task automatic rename(input logic [AW-1:0] d, input logic [RW-1:0] t);
    bus.rfUpdateValid = 1'b1;
    bus.rfUpdateDest  = d;
    bus.rfUpdateRobId = t;
  endtask

  task automatic commit(input int c, input logic [AW-1:0] d, input logic [XL-1:0] v,
                        input logic [RW-1:0] t);
    bus.regUpdateValid[c]            = 1'b1;
    bus.regUpdateDest[c*AW +: AW]    = d;
    bus.regUpdateValue[c*XL +: XL]   = v;
    bus.regUpdateRobId[c*RW +: RW]   = t;
  endtask

  function automatic logic [XL-1:0] rd_val(input int p);
    return bus.rdValue[p*XL +: XL];
  endfunction

  function automatic logic [RW-1:0] rd_dep(input int p);
    return bus.rdDependency[p*RW +: RW];
  endfunction

  function automatic logic [RW-1:0] rob_dep(input int p);
    return bus.robRdDep[p*RW +: RW];
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    set_addr(0, 5'd5);
    set_addr(1, 5'd0);
    step();
    step();
    total++;
    if ({bus.rdDirty, bus.rdValue, bus.rdDependency, bus.robRdDep} !== '0) begin
      bad++;
      $display("FAIL reset_outputs dirty=%b value=%h dep=%h robdep=%h exp all zero",
               bus.rdDirty, bus.rdValue, bus.rdDependency, bus.robRdDep);
    end
    rst_n = 1'b1;
    step();
    for (int p = 0; p < RP; p++) begin
      total++;
      if (bus.rdDirty[p] !== 1'b0) begin
        bad++; $display("FAIL reset_dirty port%0d got=%b exp=0", p, bus.rdDirty[p]);
      end
      total++;
      if (rd_val(p) !== 32'h0) begin
        bad++; $display("FAIL reset_value port%0d got=%h exp=0", p, rd_val(p));
      end
      total++;
      if (rd_dep(p) !== 4'h0) begin
        bad++; $display("FAIL reset_dep port%0d got=%h exp=0", p, rd_dep(p));
      end
      total++;
      if (rob_dep(p) !== 4'h0) begin
        bad++; $display("FAIL reset_robdep port%0d got=%h exp=0", p, rob_dep(p));
      end
    end
  endtask

  task automatic test_rename_read();
    rename(5'd3, 4'd2);
    set_addr(0, 5'd3);
    step();
    idle();
    total++;
    if (bus.rdDirty[0] !== 1'b1) begin
      bad++; $display("FAIL rename_dirty got=%b exp=1", bus.rdDirty[0]);
    end
    total++;
    if (rd_dep(0) !== 4'd2) begin
      bad++; $display("FAIL rename_dep got=%h exp=2", rd_dep(0));
    end
    total++;
    if (rob_dep(0) !== 4'd2) begin
      bad++; $display("FAIL rename_robdep got=%h exp=2", rob_dep(0));
    end
    bus.robRdReady[0]       = 1'b1;
    bus.robRdValue[0 +: XL] = 32'hAB;
    #1;
    total++;
    if (bus.rdDirty[0] !== 1'b0) begin
      bad++; $display("FAIL rob_ready_dirty got=%b exp=0", bus.rdDirty[0]);
    end
    total++;
    if (rd_val(0) !== 32'hAB) begin
      bad++; $display("FAIL rob_ready_value got=%h exp=000000ab", rd_val(0));
    end
    idle();
  endtask

  task automatic test_commit_rename_same();
    commit(0, 5'd3, 32'h1234, 4'd2);
    rename(5'd3, 4'd5);
    step();
    idle();
    total++;
    if (bus.rdDirty[0] !== 1'b1) begin
      bad++; $display("FAIL cr_busy_kept got=%b exp=1", bus.rdDirty[0]);
    end
    total++;
    if (rd_dep(0) !== 4'd5) begin
      bad++; $display("FAIL cr_new_tag got=%h exp=5", rd_dep(0));
    end
    clear = 1'b1;
    step();
    idle();
    total++;
    if (bus.rdDirty[0] !== 1'b0) begin
      bad++; $display("FAIL clear_busy got=%b exp=0", bus.rdDirty[0]);
    end
    total++;
    if (rd_val(0) !== 32'h1234) begin
      bad++; $display("FAIL cr_value got=%h exp=00001234", rd_val(0));
    end
    total++;
    if (rd_dep(0) !== 4'd5) begin
      bad++; $display("FAIL clear_tag_kept got=%h exp=5", rd_dep(0));
    end
  endtask

  task automatic test_dual_commit();
    rename(5'd7, 4'd4);
    set_addr(1, 5'd7);
    step();
    idle();
    commit(0, 5'd7, 32'h11, 4'd1);
    commit(1, 5'd7, 32'h22, 4'd4);
    step();
    idle();
    total++;
    if (bus.rdDirty[1] !== 1'b0) begin
      bad++; $display("FAIL dual_busy got=%b exp=0", bus.rdDirty[1]);
    end
    total++;
    if (rd_val(1) !== 32'h22) begin
      bad++; $display("FAIL dual_value got=%h exp=00000022", rd_val(1));
    end
    total++;
    if (rd_dep(1) !== 4'd4) begin
      bad++; $display("FAIL dual_dep got=%h exp=4", rd_dep(1));
    end
    // older port matches the tag, younger port mismatches but supplies the value
    rename(5'd11, 4'd3);
    set_addr(1, 5'd11);
    step();
    idle();
    commit(0, 5'd11, 32'h55, 4'd3);
    commit(1, 5'd11, 32'h66, 4'd9);
    step();
    idle();
    total++;
    if ({bus.rdDirty[1], rd_val(1)} !== {1'b0, 32'h66}) begin
      bad++; $display("FAIL dual_split dirty=%b value=%h exp dirty=0 value=00000066",
                      bus.rdDirty[1], rd_val(1));
    end
  endtask

  task automatic test_tag_mismatch();
    rename(5'd8, 4'd6);
    set_addr(1, 5'd8);
    step();
    idle();
    commit(0, 5'd8, 32'h44, 4'd1);
    step();
    idle();
    total++;
    if (bus.rdDirty[1] !== 1'b1) begin
      bad++; $display("FAIL mismatch_busy got=%b exp=1", bus.rdDirty[1]);
    end
    clear = 1'b1;
    step();
    idle();
    total++;
    if (rd_val(1) !== 32'h44) begin
      bad++; $display("FAIL mismatch_value got=%h exp=00000044", rd_val(1));
    end
  endtask

  task automatic test_clear_rename();
    commit(0, 5'd9, 32'h99, 4'd0);
    set_addr(0, 5'd9);
    step();
    idle();
    rename(5'd9, 4'd6);
    clear = 1'b1;
    step();
    idle();
    total++;
    if (bus.rdDirty[0] !== 1'b0) begin
      bad++; $display("FAIL clear_rename_busy got=%b exp=0", bus.rdDirty[0]);
    end
    total++;
    if (rd_val(0) !== 32'h99) begin
      bad++; $display("FAIL clear_rename_value got=%h exp=00000099", rd_val(0));
    end
    total++;
    if (rd_dep(0) !== 4'd0) begin
      bad++; $display("FAIL clear_rename_tag got=%h exp=0", rd_dep(0));
    end
  endtask

  task automatic test_read_latency();
    commit(0, 5'd12, 32'hC12, 4'd0);
    commit(1, 5'd13, 32'hD13, 4'd0);
    set_addr(1, 5'd12);
    step();
    idle();
    total++;
    if (rd_val(1) !== 32'hC12) begin
      bad++; $display("FAIL latency_first got=%h exp=00000c12", rd_val(1));
    end
    set_addr(1, 5'd13);
    #1;
    total++;
    if (rd_val(1) !== 32'hC12) begin
      bad++; $display("FAIL latency_hold got=%h exp=00000c12", rd_val(1));
    end
    step();
    total++;
    if (rd_val(1) !== 32'hD13) begin
      bad++; $display("FAIL latency_next got=%h exp=00000d13", rd_val(1));
    end
  endtask

  task automatic test_zero_reg();
    rename(5'd0, 4'd7);
    commit(0, 5'd0, 32'hDEAD, 4'd7);
    set_addr(0, 5'd0);
    set_addr(1, 5'd0);
    step();
    idle();
    bus.robRdValue = {RP{32'hFFFF_FFFF}};
    #1;
    for (int p = 0; p < RP; p++) begin
      total++;
      if ({bus.rdDirty[p], rd_val(p), rd_dep(p)} !== '0) begin
        bad++; $display("FAIL zero_reg port%0d dirty=%b value=%h dep=%h exp all zero",
                        p, bus.rdDirty[p], rd_val(p), rd_dep(p));
      end
    end
    idle();
  endtask

  task automatic test_commit_bypass();
    rename(5'd4, 4'd3);
    set_addr(0, 5'd4);
    step();
    idle();
    commit(0, 5'd4, 32'h77, 4'd3);
    #1;
`ifdef RF_COMMIT_BYPASS_EN
    total++;
    if ({bus.rdDirty[0], rd_val(0)} !== {1'b0, 32'h77}) begin
      bad++; $display("FAIL bypass_same dirty=%b value=%h exp dirty=0 value=00000077",
                      bus.rdDirty[0], rd_val(0));
    end
`else
    total++;
    if (bus.rdDirty[0] !== 1'b1) begin
      bad++; $display("FAIL no_bypass_same dirty=%b exp=1", bus.rdDirty[0]);
    end
`endif
    step();
    idle();
    total++;
    if ({bus.rdDirty[0], rd_val(0)} !== {1'b0, 32'h77}) begin
      bad++; $display("FAIL bypass_next dirty=%b value=%h exp dirty=0 value=00000077",
                      bus.rdDirty[0], rd_val(0));
    end
  endtask

  task automatic test_reset_mid();
    set_addr(0, 5'd3);
    rename(5'd3, 4'd9);
    commit(0, 5'd3, 32'hBEEF, 4'd5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    step();
    total++;
    if ({bus.rdDirty[0], rd_val(0), rd_dep(0)} !== '0) begin
      bad++; $display("FAIL reset_mid dirty=%b value=%h dep=%h exp all zero",
                      bus.rdDirty[0], rd_val(0), rd_dep(0));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad   = 0;
    clear = 1'b0;
    rst_n = 1'b0;
    bus.rdAddr = '0;
    idle();
    test_reset();
    test_rename_read();
    test_commit_rename_same();
    test_dual_commit();
    test_tag_mismatch();
    test_clear_rename();
    test_read_latency();
    test_zero_reg();
    test_commit_bypass();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
